// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out framer with optional parity bit
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int FRAME_LEN = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_C  = CW'(FRAME_LEN - 1);
  localparam logic          MSB_C   = (MSB_FIRST != 0);
  localparam logic          ODD_C   = (PARITY_ODD != 0);
  localparam logic          PAR_C   = (PARITY_EN != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             sout_d, sout_valid_d, sof_d, eof_d, busy_d;
  logic             accept;

  // A new word may enter when idle or while the last bit of the current frame is on the wire
  assign din_ready = rst & ~abort & ((state_q == IDLE) | eof);
  assign accept    = din_valid & din_ready;

  // State, datapath and output registers; every output is a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      sof        <= sof_d;
      eof        <= eof_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output decode; the shift register holds the bits not yet presented
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d      = DATA;
      cnt_d        = CW'(1);
      par_d        = (^din) ^ ODD_C;
      sout_d       = MSB_C ? din[WIDTH-1] : din[0];
      shreg_d      = MSB_C ? (din << 1) : (din >> 1);
      sout_valid_d = 1'b1;
      sof_d        = 1'b1;
    end else if (eof) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DATA: begin
          if (cnt_q < WIDTH_C) begin
            sout_d       = MSB_C ? shreg_q[WIDTH-1] : shreg_q[0];
            shreg_d      = MSB_C ? (shreg_q << 1) : (shreg_q >> 1);
            sout_valid_d = 1'b1;
            eof_d        = (cnt_q == LAST_C);
            cnt_d        = cnt_q + CW'(1);
          end else if (PAR_C) begin
            state_d      = PAR;
            sout_d       = par_q;
            sout_valid_d = 1'b1;
            eof_d        = 1'b1;
            cnt_d        = cnt_q + CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PAR: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       abort = 1'b0;

  logic rdy0, so0, sv0, sof0, eof0, bsy0;
  logic rdy1, so1, sv1, sof1, eof1, bsy1;
  logic rdy2, so2, sv2, sof2, eof2, bsy2;
  logic [4:0] obs0, obs1, obs2;

  int tests = 0;
  int fails = 0;

  // {sout, sout_valid, sof, eof, busy}
  assign obs0 = {so0, sv0, sof0, eof0, bsy0};
  assign obs1 = {so1, sv1, sof1, eof1, bsy1};
  assign obs2 = {so2, sv2, sof2, eof2, bsy2};

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy0), .abort(abort),
    .sout(so0), .sout_valid(sv0), .sof(sof0), .eof(eof0), .busy(bsy0));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy1), .abort(abort),
    .sout(so1), .sout_valid(sv1), .sof(sof1), .eof(eof1), .busy(bsy1));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy2), .abort(abort),
    .sout(so2), .sout_valid(sv2), .sof(sof2), .eof(eof2), .busy(bsy2));

  // Expected output bundle for frame bit i (0..8) carrying value b
  function automatic logic [4:0] exp_bit(input logic b, input int i);
    return {b, 1'b1, i == 0, i == 8, 1'b1};
  endfunction

  task automatic test_reset();
    #12;
    @(negedge clk);
    tests++;
    if (obs0 !== 5'b0) begin fails++; $display("FAIL reset_outputs: got %b expected %b", obs0, 5'b0); end
    tests++;
    if (rdy0 !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", rdy0); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy0 !== 1'b1 || bsy0 !== 1'b0) begin
      fails++; $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", rdy0, bsy0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [8:0] f = 9'b101001010;
    din = 8'hA5; din_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy0 !== 1'b1) begin fails++; $display("FAIL basic_ready_c0: got %b expected 1", rdy0); end
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++;
      if (obs0 !== exp_bit(f[8-i], i)) begin
        fails++; $display("FAIL basic_bit%0d: got %b expected %b", i, obs0, exp_bit(f[8-i], i));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (obs0 !== 5'b0) begin fails++; $display("FAIL basic_idle: got %b expected %b", obs0, 5'b0); end
    @(posedge clk); #1;
  endtask

  task automatic test_odd_parity();
    logic [8:0] f = 9'b101001011;
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++;
      if (obs1 !== exp_bit(f[8-i], i)) begin
        fails++; $display("FAIL odd_bit%0d: got %b expected %b", i, obs1, exp_bit(f[8-i], i));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lsb_first();
    logic [8:0] f = 9'b100000001;
    din = 8'h01; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++;
      if (obs2 !== exp_bit(f[8-i], i)) begin
        fails++; $display("FAIL lsb_bit%0d: got %b expected %b", i, obs2, exp_bit(f[8-i], i));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] f1 = 9'b101001010;
    logic [8:0] f2 = 9'b001111000;
    logic       b;
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h3C;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      b = (c <= 9) ? f1[8-((c-1)%9)] : f2[8-((c-1)%9)];
      tests++;
      if (obs0 !== exp_bit(b, (c-1)%9)) begin
        fails++; $display("FAIL b2b_cycle%0d: got %b expected %b", c, obs0, exp_bit(b, (c-1)%9));
      end
      if (c <= 17) begin
        tests++;
        if (rdy0 !== (c == 9)) begin
          fails++; $display("FAIL b2b_ready_cycle%0d: got %b expected %b", c, rdy0, c == 9);
        end
      end
      @(posedge clk); #1;
      if (c == 9) din_valid = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (obs0 !== 5'b0) begin fails++; $display("FAIL b2b_idle: got %b expected %b", obs0, 5'b0); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_midframe();
    logic [8:0] f = 9'b101001010;
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) begin din = 8'hFF; din_valid = 1'b1; end
      @(negedge clk);
      tests++;
      if (obs0 !== exp_bit(f[9-c], c-1)) begin
        fails++; $display("FAIL ignore_cycle%0d: got %b expected %b", c, obs0, exp_bit(f[9-c], c-1));
      end
      if (c == 4) begin
        tests++;
        if (rdy0 !== 1'b0) begin fails++; $display("FAIL ignore_ready: got %b expected 0", rdy0); end
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (obs0 !== 5'b0) begin fails++; $display("FAIL ignore_idle: got %b expected %b", obs0, 5'b0); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [8:0] f = 9'b101001010;
    logic [8:0] g = 9'b001111000;
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) abort = 1'b1;
      @(negedge clk);
      tests++;
      if (obs0 !== exp_bit(f[9-c], c-1)) begin
        fails++; $display("FAIL abort_pre_cycle%0d: got %b expected %b", c, obs0, exp_bit(f[9-c], c-1));
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    din = 8'h3C; din_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (obs0 !== 5'b0 || rdy0 !== 1'b1) begin
      fails++; $display("FAIL abort_cleared: got obs=%b ready=%b expected obs=00000 ready=1", obs0, rdy0);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++;
      if (obs0 !== exp_bit(g[8-i], i)) begin
        fails++; $display("FAIL abort_next_bit%0d: got %b expected %b", i, obs0, exp_bit(g[8-i], i));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] f = 9'b101001010;
    logic [8:0] g = 9'b010110100;
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      tests++;
      if (obs0 !== exp_bit(f[9-c], c-1)) begin
        fails++; $display("FAIL arst_pre_cycle%0d: got %b expected %b", c, obs0, exp_bit(f[9-c], c-1));
      end
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (obs0 !== 5'b0 || rdy0 !== 1'b0) begin
      fails++; $display("FAIL arst_immediate: got obs=%b ready=%b expected obs=00000 ready=0", obs0, rdy0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    din = 8'h5A; din_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy0 !== 1'b1 || obs0 !== 5'b0) begin
      fails++; $display("FAIL arst_release: got obs=%b ready=%b expected obs=00000 ready=1", obs0, rdy0);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++;
      if (obs0 !== exp_bit(g[8-i], i)) begin
        fails++; $display("FAIL arst_next_bit%0d: got %b expected %b", i, obs0, exp_bit(g[8-i], i));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_parity();
    test_lsb_first();
    test_back_to_back();
    test_ignore_midframe();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out framer for the secure-link transmit path.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, with an optional parity bit appended.
- Provides frame strobes (sof/eof) and the serial bit stream that the downstream single-bit retiming flop samples.

Parameters:
- WIDTH, 8, data word width; legal range 2..32.
- MSB_FIRST, 1, 1 = emit din[WIDTH-1] first; 0 = emit din[0] first.
- PARITY_EN, 1, 1 = append one parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity (total ones incl. parity bit is even); 1 = odd parity.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word, sampled on handshake.
- din_valid  input  1  word available.
- din_ready  output  1  block can accept a word this cycle.
- abort  input  1  synchronous frame abort.
- sout  output  1  serial bit, registered.
- sout_valid  output  1  sout carries a frame bit this cycle.
- sof  output  1  high with the first bit of a frame.
- eof  output  1  high with the last bit of a frame (parity bit if PARITY_EN, else last data bit).
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - state = IDLE; shift register and bit counter = 0.
  - sout = 0, sout_valid = 0, sof = 0, eof = 0, busy = 0.
  - din_ready is forced to 0 while rst is low.
- FRAME_LEN = WIDTH + PARITY_EN. Bit counter width is clog2(FRAME_LEN+1).
- States:
  - IDLE: no frame in progress.
  - DATA: emitting data bits.
  - PAR: emitting the parity bit; only reachable when PARITY_EN = 1.
- din_ready (combinational) = rst & ~abort & (state == IDLE | eof).
- Handshake occurs on a posedge where din_valid & din_ready are both high. Loading at that edge:
  - shift register and parity accumulator are loaded from din;
  - sout = first bit, sout_valid = 1, sof = 1;
  - state moves to DATA and the counter is set to 1.
  - Latency: first bit is visible in the cycle immediately after the accepting edge.
- Each subsequent posedge in DATA:
  - shift by one (direction per MSB_FIRST) and present the next bit; counter increments; sof = 0.
  - eof = 1 when the presented bit is the last bit of the frame.
- After the last data bit:
  - PARITY_EN = 1: next edge goes to PAR; sout = (XOR of the word) ^ PARITY_ODD; eof = 1.
  - PARITY_EN = 0: eof is already high with the last data bit.
- End of frame (edge following an eof cycle):
  - With a handshake: load the new word exactly as above. Output is gapless, sof directly follows eof, and sout_valid stays 1.
  - Without a handshake: return to IDLE with sout_valid = 0, sof = 0, eof = 0, sout = 0.
- din_valid while busy and not in the eof cycle is ignored; the word is not consumed.
- din is don't-care when din_valid is low.
- abort:
  - Edge with abort high: state = IDLE, counter = 0, all outputs go to their reset values. The partial frame is dropped and no eof is issued for it.
  - abort has priority over a same-cycle handshake (din_ready is 0 while abort is high).
  - abort in IDLE has no effect.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). After release, the block is in IDLE and din_ready = 1 in the first cycle.
- No output glitches: sout, sout_valid, sof, eof and busy are all flop outputs.

Test Plan:
- WIDTH=8, MSB_FIRST=1, PARITY_EN=1, PARITY_ODD=0; single din=8'hA5 -> sout over 9 cycles = 1,0,1,0,0,1,0,1,0.
  - sof in cycle 1 only, eof in cycle 9 only, sout_valid high for exactly 9 cycles, then IDLE.
- Same config with PARITY_ODD=1, din=8'hA5 -> parity bit = 1.
  - Repeat with MSB_FIRST=0, din=8'h01 -> bits 1,0,0,0,0,0,0,0 then parity 1 (PARITY_ODD=0).
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> 18 contiguous sout_valid cycles.
  - Second frame = 0,0,1,1,1,1,0,0,0; sof in cycles 1 and 10; din_ready high only in cycles 0 (IDLE) and 9.
- din_valid pulsed mid-frame (cycle 4) with 8'hFF -> word ignored, current frame unaffected, no handshake recorded.
- abort in cycle 5 of an 8'hA5 frame -> sout_valid = 0 from the next cycle, no eof, busy = 0.
  - A new word offered in the next cycle is accepted and transmitted correctly.
- rst pulled low asynchronously between clock edges in cycle 3 -> all outputs 0 before the next edge.
  - After release, din_ready = 1 and 8'h5A transmits as 0,1,0,1,1,0,1,0,0.
